// File: rtl/div_rate_ctrl.sv
// Playback-speed controller: merges speed requests into a saturated divisor and commits it at a divider edge or timeout.
// Optional speed_level output is enabled by defining SPEED_LEVEL_EN.
module div_rate_ctrl #(
    parameter int unsigned BASE_DIV = 1136,
    parameter int unsigned STEP     = 32,
    parameter int unsigned MIN_DIV  = 568,
    parameter int unsigned MAX_DIV  = 2272,
    parameter int unsigned TIMEOUT  = 8192
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              speed_up,
    input  logic              speed_down,
    input  logic              speed_reset,
    input  logic              div_clk,
    output logic [31:0]       div_factor,
    output logic              div_load,
    output logic              busy,
    output logic              at_min,
    output logic              at_max
`ifdef SPEED_LEVEL_EN
    ,
    output logic signed [7:0] speed_level
`endif
);

    // state     | meaning
    // IDLE      | div_factor matches pending, nothing to commit
    // WAIT_EDGE | change pending, waiting for a divider edge or timeout
    // COMMIT    | one cycle; div_factor takes pending on exit
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    localparam logic [31:0] BASE_V = 32'(BASE_DIV);
    localparam logic [31:0] STEP_V = 32'(STEP);
    localparam logic [31:0] MIN_V  = 32'(MIN_DIV);
    localparam logic [31:0] MAX_V  = 32'(MAX_DIV);
    localparam logic [32:0] UP_LIM = 33'(MIN_DIV) + 33'(STEP);
    localparam logic [32:0] DN_LIM = 33'(MAX_DIV) - 33'(STEP);

    state_t        state;
    logic [31:0]   pending;
    logic [31:0]   next_pending;
    logic [32:0]   pend_ext;
    logic [TW-1:0] timer;
    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          div_edge;

`ifdef SPEED_LEVEL_EN
    logic signed [7:0] level_pend;
    logic signed [7:0] next_level;
`endif

    assign pend_ext = {1'b0, pending};
    assign div_edge = sync2 & ~sync3;
    assign at_min   = (div_factor == MIN_V);
    assign at_max   = (div_factor == MAX_V);

    // Clamped steps still count as accepted requests but do not move the level.
    always_comb begin
        next_pending = pending;
`ifdef SPEED_LEVEL_EN
        next_level = level_pend;
`endif
        if (speed_reset) begin
            next_pending = BASE_V;
`ifdef SPEED_LEVEL_EN
            next_level = 8'sd0;
`endif
        end else if (speed_up && speed_down) begin
            next_pending = pending;
        end else if (speed_up) begin
            if (pend_ext < UP_LIM) begin
                next_pending = MIN_V;
            end else begin
                next_pending = pending - STEP_V;
`ifdef SPEED_LEVEL_EN
                next_level = level_pend + 8'sd1;
`endif
            end
        end else if (speed_down) begin
            if (pend_ext > DN_LIM) begin
                next_pending = MAX_V;
            end else begin
                next_pending = pending + STEP_V;
`ifdef SPEED_LEVEL_EN
                next_level = level_pend - 8'sd1;
`endif
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pending    <= BASE_V;
            div_factor <= BASE_V;
            div_load   <= 1'b0;
            timer      <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
`ifdef SPEED_LEVEL_EN
            level_pend  <= 8'sd0;
            speed_level <= 8'sd0;
`endif
        end else begin
            sync1    <= div_clk;
            sync2    <= sync1;
            sync3    <= sync2;
            div_load <= 1'b0;
            pending  <= next_pending;
`ifdef SPEED_LEVEL_EN
            level_pend <= next_level;
`endif
            case (state)
                IDLE: begin
                    if (next_pending != div_factor) begin
                        state <= WAIT_EDGE;
                        busy  <= 1'b1;
                        timer <= TIMER_LOAD;
                    end
                end
                WAIT_EDGE: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                    if (next_pending == div_factor) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (div_edge || (timer == '0)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    div_factor <= pending;
                    div_load   <= 1'b1;
`ifdef SPEED_LEVEL_EN
                    speed_level <= level_pend;
`endif
                    // A request landing in the commit cycle starts a fresh wait.
                    if (next_pending != pending) begin
                        state <= WAIT_EDGE;
                        busy  <= 1'b1;
                        timer <= TIMER_LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Directed self-checking bench for div_rate_ctrl, built with a short timeout (64 cycles).
module tb_div_rate_ctrl;

    logic        clk_50;
    logic        reset;
    logic        speed_up;
    logic        speed_down;
    logic        speed_reset;
    logic        div_clk;
    logic [31:0] div_factor;
    logic        div_load;
    logic        busy;
    logic        at_min;
    logic        at_max;
`ifdef SPEED_LEVEL_EN
    logic signed [7:0] speed_level;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    div_rate_ctrl #(
        .BASE_DIV(1136),
        .STEP    (32),
        .MIN_DIV (568),
        .MAX_DIV (2272),
        .TIMEOUT (64)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .speed_reset(speed_reset),
        .div_clk    (div_clk),
        .div_factor (div_factor),
        .div_load   (div_load),
        .busy       (busy),
        .at_min     (at_min),
        .at_max     (at_max)
`ifdef SPEED_LEVEL_EN
        ,
        .speed_level(speed_level)
`endif
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL reset_div_factor: got %0d expected 1136", div_factor); end
        n_tests++; if (div_load !== 1'b0) begin n_fail++; $display("FAIL reset_div_load: got %0b expected 0", div_load); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_tests++; if (at_min !== 1'b0) begin n_fail++; $display("FAIL reset_at_min: got %0b expected 0", at_min); end
        n_tests++; if (at_max !== 1'b0) begin n_fail++; $display("FAIL reset_at_max: got %0b expected 0", at_max); end
`ifdef SPEED_LEVEL_EN
        n_tests++; if (speed_level !== 8'sd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", speed_level); end
`endif
        tick();
    endtask

    task automatic test_single_step;
        int early;
        int late;
        div_clk = 1'b0;
        tick();
        speed_up = 1'b1;
        tick();
        speed_up = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL step_busy: got %0b expected 1", busy); end
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL step_hold: got %0d expected 1136", div_factor); end
        for (int i = 0; i < 5; i++) tick();
        div_clk = 1'b1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (div_load) early++;
        end
        n_tests++; if (early !== 0) begin n_fail++; $display("FAIL step_early_load: got %0d loads expected 0", early); end
        tick();
        n_tests++; if (div_load !== 1'b1) begin n_fail++; $display("FAIL step_load: got %0b expected 1", div_load); end
        n_tests++; if (div_factor !== 32'd1104) begin n_fail++; $display("FAIL step_div_factor: got %0d expected 1104", div_factor); end
        tick();
        n_tests++; if (div_load !== 1'b0) begin n_fail++; $display("FAIL step_load_width: got %0b expected 0", div_load); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_busy_after: got %0b expected 0", busy); end
        late = 0;
        for (int t = 0; t < 20; t++) begin
            div_clk = ((t + 5) / 8) % 2 == 0;
            tick();
            if (div_load) late++;
        end
        div_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (div_load) late++;
        end
        n_tests++; if (late !== 0) begin n_fail++; $display("FAIL step_extra_load: got %0d loads expected 0", late); end
    endtask

    task automatic test_timeout_saturation;
        int cnt;
        int lt;
        cnt = 0;
        lt  = -1;
        div_clk = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int t = 0; t < 80; t++) begin
            speed_up = (t < 40) && (t % 2 == 0);
            tick();
            if (div_load) begin cnt++; lt = t; end
        end
        speed_up = 1'b0;
        n_tests++; if (cnt !== 1) begin n_fail++; $display("FAIL timeout_load_count: got %0d expected 1", cnt); end
        n_tests++; if (lt !== 65) begin n_fail++; $display("FAIL timeout_load_cycle: got %0d expected 65", lt); end
        n_tests++; if (div_factor !== 32'd568) begin n_fail++; $display("FAIL timeout_div_factor: got %0d expected 568", div_factor); end
        n_tests++; if (at_min !== 1'b1) begin n_fail++; $display("FAIL timeout_at_min: got %0b expected 1", at_min); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %0b expected 0", busy); end
`ifdef SPEED_LEVEL_EN
        n_tests++; if (speed_level !== 8'sd17) begin n_fail++; $display("FAIL timeout_level: got %0d expected 17", speed_level); end
`endif
    endtask

    task automatic test_cancel_priority;
        int cnt;
        do_reset();
        div_clk = 1'b0;
        tick();
        speed_up = 1'b1;
        tick();
        speed_up = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_set: got %0b expected 1", busy); end
        tick();
        speed_down = 1'b1;
        tick();
        speed_down = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_clear: got %0b expected 0", busy); end
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (div_load) cnt++;
        end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL cancel_no_load: got %0d loads expected 0", cnt); end
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL cancel_div_factor: got %0d expected 1136", div_factor); end

        speed_up   = 1'b1;
        speed_down = 1'b1;
        tick();
        speed_up   = 1'b0;
        speed_down = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy: got %0b expected 0", busy); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy_later: got %0b expected 0", busy); end

        speed_down = 1'b1;
        tick();
        tick();
        speed_down  = 1'b0;
        speed_reset = 1'b1;
        speed_up    = 1'b1;
        tick();
        speed_reset = 1'b0;
        speed_up    = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy: got %0b expected 0", busy); end
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (div_load) cnt++;
        end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL reset_prio_no_load: got %0d loads expected 0", cnt); end
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL reset_prio_div_factor: got %0d expected 1136", div_factor); end
    endtask

    task automatic test_upper_bound;
        int cnt;
        int peak;
        int pulses;
        cnt    = 0;
        peak   = 0;
        pulses = 0;
        for (int t = 0; t < 260; t++) begin
            div_clk    = (t / 8) % 2 == 1;
            speed_down = (t < 144) && (t % 4 == 0);
            if (speed_down) pulses++;
            tick();
            if (div_load) cnt++;
            if (int'(div_factor) > peak) peak = int'(div_factor);
        end
        speed_down = 1'b0;
        div_clk    = 1'b0;
        n_tests++; if (pulses !== 36) begin n_fail++; $display("FAIL upper_pulses: got %0d expected 36", pulses); end
        n_tests++; if (div_factor !== 32'd2272) begin n_fail++; $display("FAIL upper_div_factor: got %0d expected 2272", div_factor); end
        n_tests++; if (at_max !== 1'b1) begin n_fail++; $display("FAIL upper_at_max: got %0b expected 1", at_max); end
        n_tests++; if (peak > 2272) begin n_fail++; $display("FAIL upper_peak: got %0d required at most 2272", peak); end
        n_tests++; if (cnt < 1) begin n_fail++; $display("FAIL upper_loads: got %0d loads expected at least 1", cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL upper_busy: got %0b expected 0", busy); end
`ifdef SPEED_LEVEL_EN
        n_tests++; if (speed_level !== -8'sd35) begin n_fail++; $display("FAIL upper_level: got %0d expected -35", speed_level); end
`endif
    endtask

    task automatic test_reset_mid;
        int cnt;
        do_reset();
        div_clk = 1'b0;
        tick();
        speed_up = 1'b1;
        tick();
        speed_up = 1'b0;
        tick();
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %0b expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL mid_div_factor: got %0d expected 1136", div_factor); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        n_tests++; if (div_load !== 1'b0) begin n_fail++; $display("FAIL mid_div_load: got %0b expected 0", div_load); end
        div_clk = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (div_load) cnt++;
        end
        div_clk = 1'b0;
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL mid_no_load: got %0d loads expected 0", cnt); end
        n_tests++; if (div_factor !== 32'd1136) begin n_fail++; $display("FAIL mid_div_factor_after: got %0d expected 1136", div_factor); end
    endtask

    initial begin
        reset       = 1'b1;
        speed_up    = 1'b0;
        speed_down  = 1'b0;
        speed_reset = 1'b0;
        div_clk     = 1'b0;
        test_reset();
        test_single_step();
        test_timeout_saturation();
        test_cancel_priority();
        test_upper_bound();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within 500000 ns expected completion");
        $fatal(1);
    end

endmodule
